axi_lite_rr_arbiter: RTL
========================

AXI_LITE_RR_ARBITER -- requirements
Module: axi_lite_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTER, default 4, giving the number of requesting masters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the cycles allowed for a slave handshake before an error is forced.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of aclk.
REQ-004 Port aclk, input, 1: clock.
REQ-005 Port areset, input, 1: synchronous active-high reset.
REQ-006 Port axim[NUM_MASTER], axi_lite_if.master modport array: requesting masters.
REQ-007 Port axis, axi_lite_if.slave modport: single shared slave.
REQ-008 Port grant_id, output, $clog2(NUM_MASTER): index of the master currently owning the slave.
REQ-009 Port busy, output, 1: high while a transaction is in flight (state not IDLE).
REQ-010 Port timeout_err, output, 1: one-cycle pulse when a timeout fires.

Function
REQ-011 The FSM SHALL have states IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP and TO_RESP.
REQ-012 A master's request SHALL be arvalid OR awvalid; in IDLE, grant goes to the first requester at or after rr_ptr, wrapping modulo NUM_MASTER.
REQ-013 The granted master's arvalid SHALL win over its awvalid; IDLE then goes to RD_ADDR, otherwise to WR_REQ.
REQ-014 grant_id SHALL register on the IDLE cycle; a request seen in IDLE at cycle t SHALL appear on axis at t+1.
REQ-015 RD_ADDR SHALL forward the granted master's araddr and arvalid and return arready; it goes to RD_RESP on the arvalid&&arready cycle.
REQ-016 RD_RESP SHALL forward rdata, rresp, rvalid and rready; it goes to IDLE on rvalid&&rready.
REQ-017 WR_REQ SHALL forward AW and W channels independently, using sticky aw_done and w_done flags to gate each valid after its handshake.
REQ-018 WR_REQ SHALL go to WR_RESP in the cycle both flags are set, including a simultaneous AW and W handshake; WR_RESP goes to IDLE on bvalid&&bready.
REQ-019 On return to IDLE, rr_ptr SHALL become grant_id+1 modulo NUM_MASTER (wrap from NUM_MASTER-1 to 0).
REQ-020 Non-granted masters SHALL see every ready and valid held at 0, with rdata, rresp and bresp at 0.
REQ-021 The slave SHALL see all valids and readies at 0 when in IDLE and TO_RESP.
REQ-022 A timeout counter SHALL clear on state entry and on any axis handshake, and increment in every other non-IDLE cycle.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL pulse timeout_err and enter TO_RESP.
REQ-024 TO_RESP SHALL give the granted master rvalid (read) or bvalid (write) with resp 2'b10 (SLVERR) and rdata 0, and go to IDLE on the master's ready.
REQ-025 The block SHALL discard any late slave response: rready and bready stay asserted toward the slave only in RD_RESP and WR_RESP.
REQ-026 With no requests in IDLE, the block SHALL hold state and rr_ptr unchanged.

Reset
REQ-027 Reset SHALL set state to IDLE, rr_ptr to 0, grant_id to 0, busy to 0, timeout_err to 0, aw_done and w_done to 0, and the counter to 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction without generating any response to the master.

Structure
REQ-029 The arbiter state enum and the resp encodings (OKAY=2'b00, SLVERR=2'b10) SHALL reside in axi_lite_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_select (inputs req vector and rr_ptr; outputs valid and index), purely combinational.
REQ-031 The FSM, counter and channel muxes SHALL reside in axi_lite_rr_arbiter.

Verification
REQ-032 Masters 0 and 2 raise arvalid together, rr_ptr=0 -> master 0 granted, axis.arvalid at t+1, master 2 served next, then rr_ptr=3.
REQ-033 All four masters request continuously -> grant order 0,1,2,3,0; no master is granted twice before all others are served.
REQ-034 Master 1 write, slave asserts wready 2 cycles before awready -> one W and one AW handshake each, then WR_RESP, bresp is passed through to master 1.
REQ-035 Slave never asserts arready, TIMEOUT_CYCLES=16 -> timeout_err pulses 16 cycles after RD_ADDR entry, master sees rvalid with rresp=2'b10 and rdata=0.
REQ-036 areset is asserted during RD_RESP -> next cycle state=IDLE, busy=0, all axis valids 0, rr_ptr=0.
REQ-037 Master 3 asserts arvalid and awvalid together -> read completes first, then master 0 (if it is requesting) is granted before master 3's write.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared widths, arbiter state encoding and AXI response codes
package axi_lite_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP, TO_RESP} arb_state_t;
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bundle; modports are seen from the arbiter (master = port facing a master)
interface axi_lite_if;
  import axi_lite_pkg::*;
  logic [ADDR_W-1:0] awaddr;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic arvalid;
  logic arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rr_select.sv
// rr_select: first requester at or after ptr, wrapping modulo N
module rr_select #(
  parameter int N = 4
) (
  input logic [N-1:0] req,
  input logic [$clog2(N)-1:0] ptr,
  output logic valid,
  output logic [$clog2(N)-1:0] index
);
  localparam int W = $clog2(N);
  logic [W-1:0] j;
  assign valid = |req;
  // scan farthest offset first so the nearest requester overwrites
  always_comb begin
    index = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) index = j;
    end
  end
endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: round-robin N:1 AXI4-Lite arbiter, one transaction at a time
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_MASTER = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic aclk,
  input logic areset,
  axi_lite_if.master axim [NUM_MASTER],
  axi_lite_if.slave axis,
  output logic [$clog2(NUM_MASTER)-1:0] grant_id,
  output logic busy,
  output logic timeout_err
);
  localparam int IW = $clog2(NUM_MASTER);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state, state_n;
  logic [IW-1:0] rr_ptr, sel_idx, grant_nxt;
  logic sel_valid, rd, aw_done, w_done;
  logic [CW-1:0] cnt;
  logic [NUM_MASTER-1:0] req, arv, awv, wv, rrdy, brdy;
  logic [ADDR_W-1:0] araddr [NUM_MASTER];
  logic [ADDR_W-1:0] awaddr [NUM_MASTER];
  logic [DATA_W-1:0] wdata [NUM_MASTER];
  logic [DATA_W/8-1:0] wstrb [NUM_MASTER];
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, hs, to_fire, m_ready;
  for (genvar i = 0; i < NUM_MASTER; i++) begin : g_m
    logic s;
    assign s = grant_id == IW'(i);
    assign arv[i] = axim[i].arvalid;
    assign awv[i] = axim[i].awvalid;
    assign wv[i] = axim[i].wvalid;
    assign rrdy[i] = axim[i].rready;
    assign brdy[i] = axim[i].bready;
    assign araddr[i] = axim[i].araddr;
    assign awaddr[i] = axim[i].awaddr;
    assign wdata[i] = axim[i].wdata;
    assign wstrb[i] = axim[i].wstrb;
    assign req[i] = arv[i] | awv[i];
    assign axim[i].arready = s && state == RD_ADDR && axis.arready;
    assign axim[i].rvalid = s && (state == RD_RESP ? axis.rvalid : state == TO_RESP && rd);
    assign axim[i].rdata = s && state == RD_RESP ? axis.rdata : '0;
    assign axim[i].rresp = s && state == RD_RESP ? axis.rresp : s && state == TO_RESP && rd ? RESP_SLVERR : RESP_OKAY;
    assign axim[i].awready = s && state == WR_REQ && !aw_done && axis.awready;
    assign axim[i].wready = s && state == WR_REQ && !w_done && axis.wready;
    assign axim[i].bvalid = s && (state == WR_RESP ? axis.bvalid : state == TO_RESP && !rd);
    assign axim[i].bresp = s && state == WR_RESP ? axis.bresp : s && state == TO_RESP && !rd ? RESP_SLVERR : RESP_OKAY;
  end
  rr_select #(.N(NUM_MASTER)) u_sel (
    .req(req),
    .ptr(rr_ptr),
    .valid(sel_valid),
    .index(sel_idx)
  );
  assign axis.araddr = araddr[grant_id];
  assign axis.arvalid = state == RD_ADDR && arv[grant_id];
  assign axis.rready = state == RD_RESP && rrdy[grant_id];
  assign axis.awaddr = awaddr[grant_id];
  assign axis.awvalid = state == WR_REQ && !aw_done && awv[grant_id];
  assign axis.wdata = wdata[grant_id];
  assign axis.wstrb = wstrb[grant_id];
  assign axis.wvalid = state == WR_REQ && !w_done && wv[grant_id];
  assign axis.bready = state == WR_RESP && brdy[grant_id];
  assign ar_hs = axis.arvalid && axis.arready;
  assign r_hs = axis.rvalid && axis.rready;
  assign aw_hs = axis.awvalid && axis.awready;
  assign w_hs = axis.wvalid && axis.wready;
  assign b_hs = axis.bvalid && axis.bready;
  assign hs = ar_hs | r_hs | aw_hs | w_hs | b_hs;
  assign busy = state != IDLE;
  assign m_ready = rd ? rrdy[grant_id] : brdy[grant_id];
  assign to_fire = state inside {RD_ADDR, RD_RESP, WR_REQ, WR_RESP} && !hs && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign grant_nxt = grant_id == IW'(NUM_MASTER - 1) ? '0 : grant_id + IW'(1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (sel_valid) state_n = arv[sel_idx] ? RD_ADDR : WR_REQ;
      RD_ADDR: if (ar_hs) state_n = RD_RESP;
      RD_RESP: if (r_hs) state_n = IDLE;
      WR_REQ: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
      WR_RESP: if (b_hs) state_n = IDLE;
      TO_RESP: if (m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (to_fire) state_n = TO_RESP;
  end
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr <= '0;
      grant_id <= '0;
      rd <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_fire;
      if (state == IDLE && sel_valid) begin
        grant_id <= sel_idx;
        rd <= arv[sel_idx];
      end
      if (state != IDLE && state_n == IDLE) rr_ptr <= grant_nxt;
      aw_done <= state == WR_REQ && (aw_done || aw_hs);
      w_done <= state == WR_REQ && (w_done || w_hs);
      cnt <= (state == IDLE || state_n != state || hs) ? '0 : cnt + CW'(1);
    end
  end
endmodule
